// File: rtl/serial_cmd_pkg.sv
// Opcode table, per-opcode argument/response lengths and FSM state encoding
// for the trig-board serial command master.
package serial_cmd_pkg;

  localparam logic [7:0] CMD_VERSION      = 8'd0;
  localparam logic [7:0] CMD_SET_MODE     = 8'd1;
  localparam logic [7:0] CMD_SET_PRESCALE = 8'd2;
  localparam logic [7:0] CMD_ARM          = 8'd3;
  localparam logic [7:0] CMD_DISARM       = 8'd4;
  localparam logic [7:0] CMD_CLR_CNT      = 8'd5;
  localparam logic [7:0] CMD_SET_MASK     = 8'd6;
  localparam logic [7:0] CMD_SET_DELAY    = 8'd7;
  localparam logic [7:0] CMD_STATUS       = 8'd8;
  localparam logic [7:0] CMD_SYNC         = 8'd9;
  localparam logic [7:0] CMD_READ_CNT     = 8'd10;
  localparam logic [7:0] CMD_SET_WIDTH    = 8'd11;
  localparam logic [7:0] CMD_SOFT_TRIG    = 8'd12;
  localparam logic [7:0] CMD_ROLLING      = 8'd13;

  localparam int RESP_CNT_W = 6;

  typedef enum logic [2:0] {IDLE, SEND, GAP, RECV, DONE} state_t;

  function automatic logic [2:0] cmd_nargs(input logic [7:0] op);
    case (op)
      CMD_SET_MODE, CMD_SET_PRESCALE, CMD_SET_WIDTH: return 3'd1;
      CMD_SET_MASK, CMD_SET_DELAY:                   return 3'd4;
      default:                                       return 3'd0;
    endcase
  endfunction

  function automatic logic [RESP_CNT_W-1:0] cmd_nresp(input logic [7:0] op);
    case (op)
      CMD_VERSION, CMD_STATUS: return 6'd1;
      CMD_READ_CNT:            return 6'd32;
      default:                 return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_master.sv
// Serialises one opcode+args onto a UART tx byte port, then collects the
// fixed-length response. Define SERIAL_MASTER_TIMEOUT_EN for the response timeout.
module serial_cmd_master
  import serial_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RESP       = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_op,
  input  logic [31:0]                 cmd_arg,
  input  logic                        txBusy,
  output logic                        txStart,
  output logic [7:0]                  txData,
  input  logic                        rxReady,
  input  logic [7:0]                  rxData,
  output logic                        resp_valid,
  output logic [7:0]                  resp_data,
  output logic [$clog2(MAX_RESP)-1:0] resp_index,
  output logic                        done,
  output logic                        timeout,
  output logic                        rx_stray
);

  localparam int IDX_W = $clog2(MAX_RESP);
  localparam int CNT_W = $clog2(MAX_RESP + 1);

  state_t           state;
  logic [7:0]       op_r;
  logic [31:0]      arg_r;
  logic [2:0]       nargs_r;
  logic [CNT_W-1:0] nresp_r;
  logic [2:0]       tx_cnt;   // bytes already handed to the UART
  logic [CNT_W-1:0] rx_cnt;
  logic [7:0]       tx_byte;

`ifdef SERIAL_MASTER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timeout_r;
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    tx_byte = op_r;
    case (tx_cnt)
      3'd1:    tx_byte = arg_r[7:0];
      3'd2:    tx_byte = arg_r[15:8];
      3'd3:    tx_byte = arg_r[23:16];
      3'd4:    tx_byte = arg_r[31:24];
      default: tx_byte = op_r;
    endcase
  end

  // txStart is gated by the live txBusy so a byte is never launched into a busy UART
  assign txStart   = (state == SEND) && !txBusy;
  assign txData    = txStart ? tx_byte : 8'h00;
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_r       <= '0;
      arg_r      <= '0;
      nargs_r    <= '0;
      nresp_r    <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_index <= '0;
      rx_stray   <= 1'b0;
`ifdef SERIAL_MASTER_TIMEOUT_EN
      idle_cnt   <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      rx_stray   <= rxReady && (state != RECV);
`ifdef SERIAL_MASTER_TIMEOUT_EN
      timeout_r  <= 1'b0;
`endif
      case (state)
        IDLE: if (cmd_valid) begin
          op_r    <= cmd_op;
          arg_r   <= cmd_arg;
          nargs_r <= cmd_nargs(cmd_op);
          nresp_r <= CNT_W'(cmd_nresp(cmd_op));
          tx_cnt  <= '0;
          rx_cnt  <= '0;
          state   <= SEND;
        end
        SEND: if (!txBusy) begin
          tx_cnt <= tx_cnt + 3'd1;
          state  <= GAP;
        end
        // One dead cycle lets the UART raise txBusy before it is looked at again
        GAP: begin
`ifdef SERIAL_MASTER_TIMEOUT_EN
          idle_cnt <= '0;
`endif
          if (tx_cnt <= nargs_r)    state <= SEND;
          else if (nresp_r == '0)   state <= DONE;
          else                      state <= RECV;
        end
        RECV: begin
          if (rxReady) begin
            resp_valid <= 1'b1;
            resp_data  <= rxData;
            resp_index <= rx_cnt[IDX_W-1:0];
            rx_cnt     <= CNT_W'(rx_cnt + 1'b1);
            if (CNT_W'(rx_cnt + 1'b1) == nresp_r) state <= DONE;
`ifdef SERIAL_MASTER_TIMEOUT_EN
            idle_cnt <= '0;
          end else if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_r <= 1'b1;
            state     <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
